// File: rtl/rr_interval_tracker_pkg.sv
// rr_pkg: shared types and helpers for the RR interval tracker.
//   rr_state_e - detector FSM states
//   cnt_width  - width of the shared strobe counter (fits the longest window)
//   rr_sat     - clamp a non-negative interval to an RR_WIDTH-bit maximum
package rr_pkg;

    typedef enum logic [1:0] {LEARN, SEARCH, QRS, REFRACT} rr_state_e;

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // One counter serves learn length, idle timeout, refractory and QRS length,
    // so it must hold the largest of them (QRS compares against the value itself).
    function automatic int cnt_width(int a, int b, int c, int d);
        return $clog2(max4(a, b, c, d) + 1);
    endfunction

    function automatic logic [63:0] rr_sat(logic [63:0] diff, int rr_w);
        logic [63:0] lim;
        lim = (64'd1 << rr_w) - 64'd1;
        return (diff > lim) ? lim : diff;
    endfunction

endpackage

// File: rtl/rr_interval_tracker_if.sv
// Sample-stream / result bundle of the RR interval tracker.
//   master: drives i_sample, i_sample_valid, i_ctr; observes results
//   slave : consumes the sample stream; drives peak, RR, average,
//           threshold, window flags and timeout pulse
interface rr_interval_tracker_if #(
    parameter int DATA_WIDTH = 11,
    parameter int CTR_WIDTH  = 22,
    parameter int RR_WIDTH   = 11
);
    logic [DATA_WIDTH-1:0] i_sample;
    logic                  i_sample_valid;
    logic [CTR_WIDTH-1:0]  i_ctr;

    logic                  o_qrs_win_active;
    logic                  o_refractory_active;
    logic                  o_peak_valid;
    logic [CTR_WIDTH-1:0]  o_r_peak_sample_num;
    logic [RR_WIDTH-1:0]   o_rr_period;
    logic                  o_rr_valid;
    logic [RR_WIDTH-1:0]   o_rr_avg;
    logic                  o_rr_avg_valid;
    logic [DATA_WIDTH-1:0] o_threshold;
    logic                  o_timeout;

    modport master (
        output i_sample, i_sample_valid, i_ctr,
        input  o_qrs_win_active, o_refractory_active, o_peak_valid,
               o_r_peak_sample_num, o_rr_period, o_rr_valid, o_rr_avg,
               o_rr_avg_valid, o_threshold, o_timeout
    );

    modport slave (
        input  i_sample, i_sample_valid, i_ctr,
        output o_qrs_win_active, o_refractory_active, o_peak_valid,
               o_r_peak_sample_num, o_rr_period, o_rr_valid, o_rr_avg,
               o_rr_avg_valid, o_threshold, o_timeout
    );
endinterface

// File: rtl/rr_interval_tracker_history.sv
// rr_history_avg: N_HIST-deep circular buffer of RR periods with a running sum.
//   i_clk, i_nrst : clock, async active-low reset
//   i_clr         : synchronous clear (new record)
//   i_wr, i_rr    : write one RR period
//   o_avg         : sum >> log2(N_HIST), reads 0 until the buffer has filled once
//   o_avg_valid   : set after N_HIST writes, cleared only by reset / i_clr
module rr_history_avg #(
    parameter int RR_WIDTH = 11,
    parameter int N_HIST   = 8
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_clr,
    input  logic                i_wr,
    input  logic [RR_WIDTH-1:0] i_rr,
    output logic [RR_WIDTH-1:0] o_avg,
    output logic                o_avg_valid
);
    localparam int PW = $clog2(N_HIST);
    localparam int SW = RR_WIDTH + PW;

    logic [RR_WIDTH-1:0] hist_q [N_HIST];
    logic [PW-1:0]       wp_q;
    logic [PW-1:0]       fill_q;
    logic [SW-1:0]       sum_q, sum_d;
    logic [RR_WIDTH-1:0] avg_q;
    logic                vld_q;

    // Slots start at zero, so subtracting the overwritten slot is correct
    // even before the buffer has filled.
    assign sum_d = sum_q + SW'(i_rr) - SW'(hist_q[wp_q]);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < N_HIST; i++) hist_q[i] <= '0;
            wp_q   <= '0;
            fill_q <= '0;
            sum_q  <= '0;
            avg_q  <= '0;
            vld_q  <= 1'b0;
        end else if (i_clr) begin
            for (int i = 0; i < N_HIST; i++) hist_q[i] <= '0;
            wp_q   <= '0;
            fill_q <= '0;
            sum_q  <= '0;
            avg_q  <= '0;
            vld_q  <= 1'b0;
        end else if (i_wr) begin
            hist_q[wp_q] <= i_rr;
            wp_q         <= wp_q + 1'b1;   // power-of-two depth wraps naturally
            sum_q        <= sum_d;
            avg_q        <= RR_WIDTH'(sum_d >> PW);
            if (!vld_q) begin
                if (fill_q == PW'(N_HIST - 1)) vld_q <= 1'b1;
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    assign o_avg       = vld_q ? avg_q : '0;
    assign o_avg_valid = vld_q;
endmodule

// File: rtl/rr_interval_tracker.sv
// rr_interval_tracker: QRS detection on a feature stream with adaptive
// threshold, refractory window, search timeout and RR-interval averaging.
//   i_clk, i_nrst  : clock, async active-low reset
//   i_ce           : clock enable qualifying i_sample_valid
//   i_new_record   : synchronous clear, wins over a same-cycle strobe
//   bus (slave)    : sample stream in; peak / RR / average / threshold out
module rr_interval_tracker
    import rr_pkg::*;
#(
    parameter int DATA_WIDTH  = 11,
    parameter int CTR_WIDTH   = 22,
    parameter int RR_WIDTH    = 11,
    parameter int N_HIST      = 8,
    parameter int LEARN_LEN   = 512,
    parameter int REFRACT_LEN = 50,
    parameter int TIMEOUT_LEN = 600,
    parameter int QRS_MAX_LEN = 40,
    parameter int THR_SHIFT   = 1
) (
    input logic                  i_clk,
    input logic                  i_nrst,
    input logic                  i_ce,
    input logic                  i_new_record,
    rr_interval_tracker_if.slave bus
);
    localparam int CW = cnt_width(LEARN_LEN, TIMEOUT_LEN, REFRACT_LEN, QRS_MAX_LEN);
    localparam logic [CW-1:0] LEARN_LAST = CW'(LEARN_LEN - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_LEN - 1);
    localparam logic [CW-1:0] REF_LAST   = CW'(REFRACT_LEN - 1);
    localparam logic [CW-1:0] QRS_LAST   = CW'(QRS_MAX_LEN);

    rr_state_e             state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] max_q, thr_q, pv_q;
    logic [CTR_WIDTH-1:0]  pn_q, prev_q, rpk_q;
    logic                  has_prev_q;
    logic [RR_WIDTH-1:0]   rr_q;
    logic                  peak_vld_q, rr_vld_q, tmo_q;

    logic                  s;
    logic [DATA_WIDTH-1:0] max_d, pv_d, thr_learn, thr_decay, thr_commit, lm;
    logic [DATA_WIDTH:0]   thr_sum;
    logic [CTR_WIDTH-1:0]  pn_d, rr_diff;
    logic [63:0]           rr_full;
    logic [RR_WIDTH-1:0]   rr_d;
    logic                  commit, hist_wr;

    assign s = i_ce & bus.i_sample_valid;

    always_comb begin
        max_d = (bus.i_sample > max_q) ? bus.i_sample : max_q;
        lm    = max_d >> THR_SHIFT;
        thr_learn = (lm == '0) ? DATA_WIDTH'(1) : lm;
        thr_decay = ((thr_q >> 1) == '0) ? DATA_WIDTH'(1) : (thr_q >> 1);

        // Strictly greater: on a tie the earlier sample stays the peak.
        pv_d = (bus.i_sample > pv_q) ? bus.i_sample : pv_q;
        pn_d = (bus.i_sample > pv_q) ? bus.i_ctr    : pn_q;
        commit = (bus.i_sample < thr_q) || (cnt_q == QRS_LAST);

        // thr - thr/4 + (peak>>THR_SHIFT)/4, one guard bit, floored at 1.
        thr_sum = (DATA_WIDTH+1)'(thr_q) - (DATA_WIDTH+1)'(thr_q >> 2)
                + (DATA_WIDTH+1)'((pv_d >> THR_SHIFT) >> 2);
        if (thr_sum[DATA_WIDTH])                  thr_commit = '1;
        else if (thr_sum[DATA_WIDTH-1:0] == '0)   thr_commit = DATA_WIDTH'(1);
        else                                      thr_commit = thr_sum[DATA_WIDTH-1:0];

        // Counter wrap handled by modular subtraction in CTR_WIDTH bits.
        rr_diff = pn_d - prev_q;
        rr_full = rr_sat(64'(rr_diff), RR_WIDTH);
        rr_d    = rr_full[RR_WIDTH-1:0];

        hist_wr = s & ~i_new_record & (state_q == QRS) & commit & has_prev_q;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= LEARN;  cnt_q <= '0;  max_q <= '0;  thr_q <= '0;
            pv_q <= '0;  pn_q <= '0;  prev_q <= '0;  rpk_q <= '0;
            has_prev_q <= 1'b0;  rr_q <= '0;
            peak_vld_q <= 1'b0;  rr_vld_q <= 1'b0;  tmo_q <= 1'b0;
        end else begin
            peak_vld_q <= 1'b0;
            rr_vld_q   <= 1'b0;
            tmo_q      <= 1'b0;
            if (i_new_record) begin
                state_q <= LEARN;  cnt_q <= '0;  max_q <= '0;  thr_q <= '0;
                pv_q <= '0;  pn_q <= '0;  prev_q <= '0;  rpk_q <= '0;
                has_prev_q <= 1'b0;  rr_q <= '0;
            end else if (s) begin
                case (state_q)
                    LEARN: begin
                        max_q <= max_d;
                        if (cnt_q == LEARN_LAST) begin
                            thr_q   <= thr_learn;
                            cnt_q   <= '0;
                            state_q <= SEARCH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    SEARCH: begin
                        if (bus.i_sample > thr_q) begin
                            pv_q    <= bus.i_sample;
                            pn_q    <= bus.i_ctr;
                            cnt_q   <= CW'(1);
                            state_q <= QRS;
                        end else if (cnt_q == TMO_LAST) begin
                            thr_q <= thr_decay;
                            tmo_q <= 1'b1;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    QRS: begin
                        pv_q <= pv_d;
                        pn_q <= pn_d;
                        if (commit) begin
                            peak_vld_q <= 1'b1;
                            rpk_q      <= pn_d;
                            if (has_prev_q) begin
                                rr_q     <= rr_d;
                                rr_vld_q <= 1'b1;
                            end
                            thr_q      <= thr_commit;
                            prev_q     <= pn_d;
                            has_prev_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= REFRACT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    REFRACT: begin
                        if (cnt_q == REF_LAST) begin
                            cnt_q   <= '0;
                            state_q <= SEARCH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= LEARN;
                endcase
            end
        end
    end

    rr_history_avg #(
        .RR_WIDTH (RR_WIDTH),
        .N_HIST   (N_HIST)
    ) u_hist (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_clr       (i_new_record),
        .i_wr        (hist_wr),
        .i_rr        (rr_d),
        .o_avg       (bus.o_rr_avg),
        .o_avg_valid (bus.o_rr_avg_valid)
    );

    assign bus.o_qrs_win_active    = (state_q == QRS);
    assign bus.o_refractory_active = (state_q == REFRACT);
    assign bus.o_peak_valid        = peak_vld_q;
    assign bus.o_r_peak_sample_num = rpk_q;
    assign bus.o_rr_period         = rr_q;
    assign bus.o_rr_valid          = rr_vld_q;
    assign bus.o_threshold         = thr_q;
    assign bus.o_timeout           = tmo_q;
endmodule

// File: tb/tb_rr_interval_tracker.sv
// Scoreboard bench: stimulus pushes expected peak / timeout events,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_rr_interval_tracker;
    localparam int DW = 11;
    localparam int CW = 22;
    localparam int RW = 11;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic ce = 1'b0;
    logic nrec = 1'b0;
    always #5 clk = ~clk;

    rr_interval_tracker_if #(.DATA_WIDTH(DW), .CTR_WIDTH(CW), .RR_WIDTH(RW)) bus ();

    rr_interval_tracker #(
        .DATA_WIDTH(DW), .CTR_WIDTH(CW), .RR_WIDTH(RW), .N_HIST(4),
        .LEARN_LEN(8), .REFRACT_LEN(4), .TIMEOUT_LEN(20), .QRS_MAX_LEN(40),
        .THR_SHIFT(1)
    ) dut (
        .i_clk(clk), .i_nrst(nrst), .i_ce(ce), .i_new_record(nrec), .bus(bus)
    );

    typedef struct {
        bit          tmo;
        logic [CW-1:0] rpk;
        bit          rrv;
        logic [RW-1:0] rr;
        logic [RW-1:0] avg;
        bit          avgv;
        logic [DW-1:0] thr;
    } ev_t;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_peak(input logic [CW-1:0] rpk, input bit rrv, input int rr,
                            input int avg, input bit avgv, input int thr);
        ev_t e;
        e.tmo = 1'b0; e.rpk = rpk; e.rrv = rrv; e.rr = RW'(rr);
        e.avg = RW'(avg); e.avgv = avgv; e.thr = DW'(thr);
        q.push_back(e);
    endtask

    task automatic exp_tmo(input int thr);
        ev_t e;
        e.tmo = 1'b1; e.rpk = '0; e.rrv = 1'b0; e.rr = '0;
        e.avg = '0; e.avgv = 1'b0; e.thr = DW'(thr);
        q.push_back(e);
    endtask

    task automatic strobe(input int smp, input logic [CW-1:0] ctr, input bit c = 1'b1,
                          input bit nr = 1'b0);
        bus.i_sample       = DW'(smp);
        bus.i_ctr          = ctr;
        bus.i_sample_valid = 1'b1;
        ce                 = c;
        nrec               = nr;
        @(posedge clk);
        #1;
        bus.i_sample_valid = 1'b0;
        ce                 = 1'b0;
        nrec               = 1'b0;
    endtask

    // Peak of 196 keeps a threshold of 97 unchanged: 97 - 24 + (98 >> 2).
    task automatic do_peak(input logic [CW-1:0] ctr, input bit rrv, input int rr,
                           input int avg, input bit avgv, input int thr);
        logic [CW-1:0] c;
        exp_peak(ctr, rrv, rr, avg, avgv, thr);
        strobe(196, ctr);
        c = ctr + 1'b1;
        strobe(0, c);
        for (int i = 0; i < 4; i++) begin
            c = c + 1'b1;
            strobe(0, c);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_thr"},  bus.o_threshold, 0);
        check({tag, "_rpk"},  bus.o_r_peak_sample_num, 0);
        check({tag, "_rr"},   bus.o_rr_period, 0);
        check({tag, "_avg"},  bus.o_rr_avg, 0);
        check({tag, "_avgv"}, bus.o_rr_avg_valid, 0);
        check({tag, "_qrs"},  bus.o_qrs_win_active, 0);
        check({tag, "_ref"},  bus.o_refractory_active, 0);
        check({tag, "_pulses"}, {bus.o_peak_valid, bus.o_rr_valid, bus.o_timeout}, 0);
    endtask

    // Monitor: every pulse must match the head of the expected queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (bus.o_rr_valid && !bus.o_peak_valid)
                check("rr_valid_without_peak", 1, 0);
            if (bus.o_peak_valid || bus.o_timeout) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {bus.o_peak_valid, bus.o_timeout}, 0);
                end else begin
                    e = q.pop_front();
                    if (e.tmo) begin
                        check("tmo_pulse", {bus.o_peak_valid, bus.o_timeout}, 1);
                        check("tmo_thr", bus.o_threshold, e.thr);
                    end else begin
                        check("peak_pulse", {bus.o_peak_valid, bus.o_timeout}, 2);
                        check("peak_num", bus.o_r_peak_sample_num, e.rpk);
                        check("rr_valid", bus.o_rr_valid, e.rrv);
                        check("rr_period", bus.o_rr_period, e.rr);
                        check("rr_avg", bus.o_rr_avg, e.avg);
                        check("rr_avg_valid", bus.o_rr_avg_valid, e.avgv);
                        check("peak_thr", bus.o_threshold, e.thr);
                    end
                end
            end
        end
    end

    initial begin
        int learn_s[8];
        bus.i_sample = '0; bus.i_ctr = '0; bus.i_sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        nrst = 1'b1;
        @(posedge clk); #1;

        // 1. learn: max 200 -> threshold 100 only after the 8th real strobe
        learn_s = '{10, 50, 200, 30, 120, 0, 199, 60};
        for (int i = 0; i < 7; i++) strobe(learn_s[i], CW'(i));
        check("learn_thr_after7", bus.o_threshold, 0);
        strobe(2047, CW'(7), 1'b0);   // ce low: must not count or track max
        check("learn_thr_ce0", bus.o_threshold, 0);
        strobe(learn_s[7], CW'(8));
        check("learn_thr", bus.o_threshold, 100);

        // 2. first peak at ctr 102, threshold 100 -> 97
        strobe(50, CW'(100));
        strobe(120, CW'(101));
        check("qrs_active", bus.o_qrs_win_active, 1);
        strobe(180, CW'(102));
        strobe(150, CW'(103));
        exp_peak(CW'(102), 1'b0, 0, 0, 1'b0, 97);
        strobe(90, CW'(104));
        check("refract_active", bus.o_refractory_active, 1);
        for (int i = 0; i < 3; i++) strobe(500, CW'(105 + i));
        check("refract_still", bus.o_refractory_active, 1);
        strobe(500, CW'(108));
        check("refract_done", bus.o_refractory_active, 0);
        check("refract_thr", bus.o_threshold, 97);

        // 3. RR history: 250,250,250,258 -> 252; then 200 -> 239
        do_peak(CW'(352),  1'b1, 250, 0,   1'b0, 97);
        do_peak(CW'(602),  1'b1, 250, 0,   1'b0, 97);
        do_peak(CW'(852),  1'b1, 250, 0,   1'b0, 97);
        do_peak(CW'(1110), 1'b1, 258, 252, 1'b1, 97);
        do_peak(CW'(1310), 1'b1, 200, 239, 1'b1, 97);

        // 4. search timeout: 97 -> 48 -> 24
        exp_tmo(48);
        for (int i = 0; i < 20; i++) strobe(0, CW'(2000 + i));
        check("tmo_thr1", bus.o_threshold, 48);
        exp_tmo(24);
        for (int i = 0; i < 20; i++) strobe(0, CW'(2100 + i));
        check("tmo_thr2", bus.o_threshold, 24);

        // 5. counter wrap and RR saturation
        do_peak(CW'(4194300), 1'b1, 2047, 688,  1'b1, 42);
        do_peak(CW'(50),      1'b1, 54,   639,  1'b1, 56);
        do_peak(CW'(0),       1'b1, 2047, 1087, 1'b1, 66);
        do_peak(CW'(3000),    1'b1, 2047, 1548, 1'b1, 74);

        // 6a. async reset mid-QRS: no pulse, everything cleared
        strobe(196, CW'(5000));
        check("pre_reset_qrs", bus.o_qrs_win_active, 1);
        nrst = 1'b0;
        #1;
        check_all_zero("rst_mid_qrs");
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("after_rst");

        // relearn proves the state went back to LEARN
        for (int i = 0; i < 7; i++) strobe(200, CW'(5100 + i));
        check("relearn_thr_after7", bus.o_threshold, 0);
        strobe(200, CW'(5107));
        check("relearn_thr", bus.o_threshold, 100);

        // 6b. new record coincident with a commit strobe
        strobe(196, CW'(6000));
        check("pre_newrec_qrs", bus.o_qrs_win_active, 1);
        strobe(0, CW'(6001), 1'b1, 1'b1);
        check_all_zero("newrec_commit");
        @(posedge clk); #1;
        check_all_zero("newrec_after");

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_interval_tracker.md
Name: rr_interval_tracker

Overview:
Parametrised successor to the QRS-detect / extremum / FSM chain of the ECG core, packaged as one block. It consumes one feature sample stream (abs-diff of the moving averages) plus the global sample counter. It outputs R-peak sample number, RR period, an N-interval RR average, and a timeout flag. Threshold learning, refractory window, search-timeout threshold decay, counter wrap and RR history are all internal.

Parameters:
DATA_WIDTH, 11, feature sample width (unsigned magnitude)
CTR_WIDTH, 22, sample counter width
RR_WIDTH, 11, RR period width; saturates at 2^RR_WIDTH-1
N_HIST, 8, RR history depth; power of two, >=2
LEARN_LEN, 512, strobes of max-tracking before first threshold
REFRACT_LEN, 50, strobes ignored after each peak
TIMEOUT_LEN, 600, strobes in SEARCH without a crossing before threshold decay
QRS_MAX_LEN, 40, maximum strobes in QRS before a forced commit
THR_SHIFT, 1, threshold = peak >> THR_SHIFT

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_ce  in  1  clock enable
i_new_record  in  1  synchronous clear to reset state
i_sample  in  DATA_WIDTH  feature sample, unsigned
i_sample_valid  in  1  sample strobe; qualified by i_ce
i_ctr  in  CTR_WIDTH  sample number of i_sample
o_qrs_win_active  out  1  state==QRS
o_refractory_active  out  1  state==REFRACT
o_peak_valid  out  1  one-cycle pulse per committed peak
o_r_peak_sample_num  out  CTR_WIDTH  sample number of last peak (held)
o_rr_period  out  RR_WIDTH  last RR interval (held)
o_rr_valid  out  1  one-cycle pulse, new RR
o_rr_avg  out  RR_WIDTH  mean of last N_HIST RR
o_rr_avg_valid  out  1  level; history full
o_threshold  out  DATA_WIDTH  current threshold
o_timeout  out  1  one-cycle pulse on threshold decay

Behaviour:
- Reset and i_new_record: all outputs 0, history and sum cleared, state LEARN. i_new_record has priority over a same-cycle strobe.
- Strobe s = i_ce & i_sample_valid. All state, counters and threshold advance only on s. Pulse outputs are registered and asserted the cycle after the deciding strobe; otherwise 0.
- LEARN: track running max of i_sample. After the LEARN_LEN-th strobe: threshold = max(max >> THR_SHIFT, 1); go SEARCH.
- SEARCH:
  - i_sample > threshold (strict): latch peak_val = i_sample, peak_num = i_ctr, qrs_len = 1; go QRS.
  - Otherwise increment idle counter. On reaching TIMEOUT_LEN: threshold = max(threshold >> 1, 1), o_timeout pulse, idle counter cleared.
  - Idle counter also clears on entry to SEARCH.
- QRS:
  - i_sample > peak_val: update peak_val and peak_num. Ties keep the earlier sample.
  - Commit when i_sample < threshold or qrs_len == QRS_MAX_LEN. The commit strobe's own sample is still eligible as the peak.
  - Commit actions: o_peak_valid, o_r_peak_sample_num = peak_num.
  - If a previous peak exists: rr = (peak_num - prev_num) mod 2^CTR_WIDTH, saturated to RR_WIDTH; o_rr_period = rr; o_rr_valid.
  - Threshold update: thr - (thr>>2) + ((peak_val>>THR_SHIFT)>>2), floored at 1.
  - prev_num = peak_num; go REFRACT.
- REFRACT: input ignored for REFRACT_LEN strobes, then SEARCH.
- RR history:
  - Circular buffer N_HIST x RR_WIDTH; write pointer wraps modulo N_HIST.
  - Running sum width RR_WIDTH+log2(N_HIST): sum += new - oldest.
  - o_rr_avg = sum >> log2(N_HIST), truncating; updated with o_rr_valid.
  - o_rr_avg_valid is set once N_HIST RRs have been written, cleared only by reset or new record. o_rr_avg reads 0 while not valid.
- Reset mid-QRS: pending peak discarded, no pulse.

Decomposition:
- Package rr_pkg:
  - state enum {LEARN, SEARCH, QRS, REFRACT}
  - counter width function (clog2 of max of LEARN_LEN / TIMEOUT_LEN / REFRACT_LEN / QRS_MAX_LEN)
  - saturating RR subtraction function
- One sub-module, rr_history_avg: circular buffer, running sum, avg_valid.

Test Plan:
Common setup: LEARN_LEN=8, REFRACT_LEN=4, TIMEOUT_LEN=20, QRS_MAX_LEN=40, N_HIST=4, THR_SHIFT=1.
1. Learn: 8 strobes, max 200 -> o_threshold=100 after the 8th strobe, state SEARCH; 0 strobes with i_ce=0 change nothing.
2. First peak: samples 50,120,180,150,90 at ctr 100..104 -> one o_peak_valid after the ctr 104 strobe, r_peak=102, threshold=97, no o_rr_valid. 4 following strobes of 500 are ignored (refractory).
3. Second peak at ctr 352 -> o_rr_period=250, o_rr_valid one cycle. Then RRs 250,250,258 -> o_rr_avg=252, avg_valid=1. Next RR 200 -> avg=239.
4. Timeout: 20 strobes of 0 in SEARCH with threshold 97 -> o_timeout pulse, threshold 48; 20 more -> 24.
5. Wrap: prev peak 4194300, new peak 50 (CTR_WIDTH=22) -> rr=54. Prev 0, new 3000 -> rr=2047 (saturated).
6. Reset: nrst low for 1 cycle during QRS -> all outputs 0, state LEARN, no peak pulse. i_new_record coincident with a commit strobe -> same result.
